// File: rtl/cla8_shared_add_sched.sv
// Two-requester adder that time-shares one 8-bit carry-lookahead slice, one byte per clock,
// with round-robin arbitration and a valid/ready response port.

module carry_lookahead_adder_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       prod;
  logic       term;
  logic       acc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum of generate/propagate products; no carry feeds another carry.
  always_comb begin
    c    = '0;
    prod = 1'b0;
    term = 1'b0;
    acc  = 1'b0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      prod = cin;
      for (int j = 0; j <= i; j++) begin
        prod = prod & p[j];
      end
      acc = prod;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
  end

  assign sum  = p ^ c[7:0];
  assign cout = c[8];

endmodule

module cla8_shared_add_sched #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
);

  localparam int unsigned NB   = WIDTH / 8;
  localparam int unsigned IdxW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NB - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             id_q, id_d;
  logic             ptr_q, ptr_d;

  logic             grant;
  logic             accept;
  logic [7:0]       slice_a;
  logic [7:0]       slice_b;
  logic [7:0]       slice_sum;
  logic             slice_cout;

  // ptr_q holds the last served requester; a tie goes to the other one.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~ptr_q;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready = rst_n && (state_q == StIdle) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == StIdle) && req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < NB; s++) begin
      if (idx_q == IdxW'(s)) begin
        slice_a = a_q[8*s +: 8];
        slice_b = b_q[8*s +: 8];
      end
    end
  end

  carry_lookahead_adder_8 u_cla (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          carry_d = grant ? req1_cin : req0_cin;
          id_d    = grant;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        for (int s = 0; s < NB; s++) begin
          if (idx_q == IdxW'(s)) begin
            sum_d[8*s +: 8] = slice_sum;
          end
        end
        carry_d = slice_cout;
        // The index parks on the last slice rather than wrapping.
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (rsp_ready) begin
          state_d = StIdle;
          ptr_d   = id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      id_q    <= 1'b0;
      ptr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign rsp_valid = (state_q == StDone);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_cla8_shared_add_sched.sv
// Scoreboard bench: accepted requests push a+b+cin into a queue, a response monitor pops and
// compares; directed scenarios first, then randomized traffic.

module tb_cla8_shared_add_sched;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NB    = WIDTH / 8;

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready, req0_cin;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready, req1_cin;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [WIDTH-1:0] rsp_sum;

  cla8_shared_add_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             id;
    int               acc_cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic             id_log[$];
  logic [WIDTH-1:0] sum_log[$];
  logic             cout_log[$];
  int total, bad, cyc, n_acc, n_rsp;
  bit busy, last_id, cur_id;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request side: predicts the grant from the round-robin rule, pushes a+b+cin on acceptance.
  always @(negedge clk) begin
    logic             g1, e0, e1, k;
    logic [WIDTH:0]   full;
    exp_t             e;
    if (!rst_n) begin
      chk("ready_in_reset", {req0_ready, req1_ready}, 2'b00);
      chk("valid_in_reset", rsp_valid, 1'b0);
      exp_q.delete();
      busy    = 1'b0;
      last_id = 1'b1;
    end else begin
      e0 = 1'b0;
      e1 = 1'b0;
      if (!busy) begin
        g1 = (req0_valid && req1_valid) ? !last_id : req1_valid;
        e0 = req0_valid && !g1;
        e1 = req1_valid && g1;
      end
      chk("ready_grant", {req0_ready, req1_ready}, {e0, e1});
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        k         = req1_ready;
        full      = k ? ({1'b0, req1_a} + {1'b0, req1_b} + (WIDTH+1)'(req1_cin))
                      : ({1'b0, req0_a} + {1'b0, req0_b} + (WIDTH+1)'(req0_cin));
        e.sum     = full[WIDTH-1:0];
        e.cout    = full[WIDTH];
        e.id      = k;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        cur_id = k;
        busy   = 1'b1;
        n_acc++;
      end
      if (rsp_valid && rsp_ready) begin
        busy    = 1'b0;
        last_id = cur_id;
      end
    end
  end

  // Response side: latency, hold-while-stalled and result checks.
  bit               was_valid, p_hold;
  logic [WIDTH-1:0] p_sum;
  logic             p_cout, p_id;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      was_valid = 1'b0;
      p_hold    = 1'b0;
    end else begin
      if (p_hold) begin
        chk("hold_valid", rsp_valid, 1'b1);
        chk("hold_data", {rsp_cout, rsp_id, rsp_sum}, {p_cout, p_id, p_sum});
      end
      if (rsp_valid) begin
        chk("rsp_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          if (!was_valid) chk("latency", cyc - e.acc_cyc, NB + 1);
          if (rsp_ready) begin
            chk("sum", rsp_sum, e.sum);
            chk("cout", rsp_cout, e.cout);
            chk("id", rsp_id, e.id);
            void'(exp_q.pop_front());
            id_log.push_back(rsp_id);
            sum_log.push_back(rsp_sum);
            cout_log.push_back(rsp_cout);
            n_rsp++;
          end
        end
      end
      p_hold    = rsp_valid && !rsp_ready;
      p_sum     = rsp_sum;
      p_cout    = rsp_cout;
      p_id      = rsp_id;
      was_valid = rsp_valid;
    end
  end

  task automatic wait_rsp(input int target);
    int t = 0;
    while (n_rsp < target && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("wait_rsp", n_rsp >= target, 1'b1);
  endtask

  task automatic issue(input bit k, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin);
    int t = 0;
    bit hs = 1'b0;
    if (k) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    while (!hs && t < 50) begin
      @(negedge clk);
      hs = k ? req1_ready : req0_ready;
      t++;
    end
    chk("accept_wait", hs, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tgt, acc_base, rsp_base;
    bit hs0, hs1;
    rst_n = 1'b0;  rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    #2;
    chk("reset_outputs", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, '0);

    // Both requesters valid from reset: strict alternation 0,1,0,1.
    req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 32'h1234_5678; req1_b = 32'h1111_1111; req1_cin = 1'b1; req1_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    wait_rsp(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk("s3_id_order", id_log[i], i % 2);
    chk("s3_sum", sum_log[0], 32'h0);
    chk("s3_cout", cout_log[0], 1'b1);

    tgt = n_rsp + 1;
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    wait_rsp(tgt);
    chk("s1_sum", sum_log[$], 32'h0000_0100);
    chk("s1_cout_id", {cout_log[$], id_log[$]}, 2'b00);

    tgt = n_rsp + 1;
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_rsp(tgt);
    chk("s2_sum", sum_log[$], 32'h0);
    chk("s2_cout_id", {cout_log[$], id_log[$]}, 2'b11);

    // Stalled response with a competing request waiting.
    rsp_ready = 1'b0;
    issue(1'b0, 32'hDEAD_BEEF, 32'h0123_4567, 1'b1);
    req1_a = 32'h0F0F_0F0F; req1_b = 32'hF0F0_F0F1; req1_cin = 1'b0; req1_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 50);
    chk("s4_valid_seen", rsp_valid, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("s4_release", rsp_valid, 1'b0);
    t = 0;
    while (!req1_ready && t < 50) begin @(negedge clk); t++; end
    chk("s4_req1_ready", req1_ready, 1'b1);
    tgt = n_rsp + 1;
    @(posedge clk);
    #1 req1_valid = 1'b0;
    wait_rsp(tgt);

    // Reset in the second ADD cycle of a req1 op, right after req0 was served.
    tgt = n_rsp + 1;
    issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    wait_rsp(tgt);
    issue(1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("s5_rst_outputs", {rsp_valid, rsp_cout, rsp_id, rsp_sum}, '0);
    chk("s5_rst_ready", {req0_ready, req1_ready}, 2'b00);
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("s5_tie_req0", {req0_ready, req1_ready}, 2'b10);
    tgt = n_rsp + 1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(tgt);

    // Randomized traffic.
    acc_base = n_acc;
    rsp_base = n_rsp;
    t = 0;
    while (t < 60000) begin
      @(negedge clk);
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      t++;
      if (n_acc - acc_base >= 1000) break;
      if (hs0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_a     = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
        req0_b     = WIDTH'($urandom);
        req0_cin   = 1'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req0_valid = 1'b0;
      end
      if (hs1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_a     = WIDTH'($urandom);
        req1_b     = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
        req1_cin   = 1'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        req1_valid = 1'b0;
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    chk("s6_acc_count", n_acc - acc_base >= 1000, 1'b1);
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin @(posedge clk); #1; t++; end
    chk("s6_drain", exp_q.size(), 0);
    chk("s6_one_rsp_per_acc", n_rsp - rsp_base, n_acc - acc_base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
